// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-way traffic controller.
//   state_t    : controller FSM state (encoding doubles as the phase output)
//   LAMP_*     : per-way lamp encodings on the lights bus
//   PHASE_*    : encodings of the phase output
//   TIMER_W    : width of the in-state cycle timer
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'b00,
    ST_YELLOW  = 2'b01,
    ST_ALL_RED = 2'b10
  } state_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  localparam logic [1:0] PHASE_GREEN   = 2'b00;
  localparam logic [1:0] PHASE_YELLOW  = 2'b01;
  localparam logic [1:0] PHASE_ALL_RED = 2'b10;

  localparam int TIMER_W = 16;

  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] p;
    case (s)
      ST_YELLOW:  p = PHASE_YELLOW;
      ST_ALL_RED: p = PHASE_ALL_RED;
      default:    p = PHASE_GREEN;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per way
//   cur   : current way; it is excluded from the search
//   valid : some way other than cur is requesting
//   way   : first requesting way after cur, wrapping from N_WAYS-1 to 0
module traffic_rr_pick #(
  parameter int N_WAYS = 4,
  localparam int WAY_W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] req,
  input  logic [WAY_W-1:0]  cur,
  output logic              valid,
  output logic [WAY_W-1:0]  way
);

  logic [WAY_W:0]   sum;
  logic [WAY_W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    way   = cur;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k < N_WAYS; k++) begin
      // cur + k stays below 2*N_WAYS, so one conditional subtract wraps it
      sum = (WAY_W+1)'(cur) + (WAY_W+1)'(k);
      if (sum >= (WAY_W+1)'(N_WAYS)) sum = sum - (WAY_W+1)'(N_WAYS);
      idx = sum[WAY_W-1:0];
      if (!valid && req[idx]) begin
        valid = 1'b1;
        way   = idx;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Multi-way traffic light controller with round-robin service and
// emergency preemption.
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset (way 0 green)
//   sensor      : vehicle waiting, one bit per way
//   preempt_req : emergency preemption request (level)
//   preempt_way : way the emergency vehicle needs
//   lights      : lamp per way, lights[2i+1:2i] for way i
//   active_way  : way owning the current phase
//   phase       : GREEN / YELLOW / ALL_RED
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int N_WAYS         = 4,
  parameter int GREEN_MIN      = 4,
  parameter int GREEN_MAX      = 16,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1,
  localparam int WAY_W = $clog2(N_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_WAYS-1:0]     sensor,
  input  logic                  preempt_req,
  input  logic [WAY_W-1:0]      preempt_way,
  output logic [2*N_WAYS-1:0]   lights,
  output logic [WAY_W-1:0]      active_way,
  output logic [1:0]            phase
);

  state_t               state, state_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic [WAY_W-1:0]     next_way, next_way_nx, active_nx;
  logic [2*N_WAYS-1:0]  lights_nx;
  logic                 rr_valid;
  logic [WAY_W-1:0]     rr_way;
  logic                 pv;

  function automatic logic [2*N_WAYS-1:0] lamps(input state_t s,
                                                input logic [WAY_W-1:0] w);
    logic [2*N_WAYS-1:0] l;
    for (int i = 0; i < N_WAYS; i++) begin
      l[2*i +: 2] = LAMP_RED;
      if (WAY_W'(i) == w) begin
        if (s == ST_GREEN)       l[2*i +: 2] = LAMP_GREEN;
        else if (s == ST_YELLOW) l[2*i +: 2] = LAMP_YELLOW;
      end
    end
    return l;
  endfunction

  traffic_rr_pick #(.N_WAYS(N_WAYS)) u_rr (
    .req   (sensor),
    .cur   (active_way),
    .valid (rr_valid),
    .way   (rr_way)
  );

  // Out-of-range preemption targets are treated as no request at all
  assign pv = preempt_req && ({1'b0, preempt_way} < (WAY_W+1)'(N_WAYS));

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    next_way_nx = next_way;
    active_nx   = active_way;
    case (state)
      ST_GREEN: begin
        if (pv && (preempt_way != active_way)) begin
          state_nx    = ST_YELLOW;
          timer_nx    = '0;
          next_way_nx = preempt_way;
        end else if (!pv && rr_valid &&
                     (timer >= TIMER_W'(GREEN_MIN-1)) &&
                     (!sensor[active_way] || (timer == TIMER_W'(GREEN_MAX-1)))) begin
          state_nx    = ST_YELLOW;
          timer_nx    = '0;
          next_way_nx = rr_way;
        end else if (timer < TIMER_W'(GREEN_MAX-1)) begin
          // Saturating, so a green held by preemption yields at once on release
          timer_nx = timer + TIMER_W'(1);
        end
      end
      ST_YELLOW: begin
        if (pv) next_way_nx = preempt_way;
        if (timer >= TIMER_W'(YELLOW_CYCLES-1)) begin
          state_nx = ST_ALL_RED;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      ST_ALL_RED: begin
        if (pv) next_way_nx = preempt_way;
        if (timer >= TIMER_W'(ALL_RED_CYCLES-1)) begin
          state_nx  = ST_GREEN;
          timer_nx  = '0;
          active_nx = next_way_nx;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      default: begin
        state_nx = ST_GREEN;
        timer_nx = '0;
      end
    endcase
    lights_nx = lamps(state_nx, active_nx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_GREEN;
      timer      <= '0;
      next_way   <= '0;
      active_way <= '0;
      phase      <= PHASE_GREEN;
      lights     <= lamps(ST_GREEN, '0);
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      next_way   <= next_way_nx;
      active_way <= active_nx;
      phase      <= phase_of(state_nx);
      lights     <= lights_nx;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sensor = 4'b0000;
  logic       preempt_req = 1'b0;
  logic [1:0] preempt_way = 2'd0;
  logic [7:0] lights;
  logic [1:0] active_way;
  logic [1:0] phase;

  int tests  = 0;
  int failed = 0;

  traffic_ctrl_multi #(
    .N_WAYS(4), .GREEN_MIN(4), .GREEN_MAX(16),
    .YELLOW_CYCLES(2), .ALL_RED_CYCLES(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor      (sensor),
    .preempt_req (preempt_req),
    .preempt_way (preempt_way),
    .lights      (lights),
    .active_way  (active_way),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // Lamp pattern implied by a phase and an owning way
  function automatic logic [7:0] exp_lights(input logic [1:0] ph, input logic [1:0] w);
    logic [7:0] l;
    for (int i = 0; i < 4; i++) begin
      l[2*i +: 2] = 2'b10;
      if (i == int'(w) && ph == 2'b00) l[2*i +: 2] = 2'b00;
      if (i == int'(w) && ph == 2'b01) l[2*i +: 2] = 2'b01;
    end
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset across two edges, then release on a falling edge with new sensors
  task automatic do_reset(input logic [3:0] s);
    reset = 1'b1;
    preempt_req = 1'b0;
    preempt_way = 2'd0;
    tick(2);
    sensor = s;
    reset  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    if (phase !== 2'b00 || active_way !== 2'd0 || lights !== 8'b10101000) begin
      $display("FAIL reset_state: phase=%0d way=%0d lights=%b, want 0 0 10101000",
               phase, active_way, lights);
      failed++;
    end
    tests++;
  endtask

  task automatic test_rest_green;
    do_reset(4'b0001);
    for (int i = 0; i < 40; i++) begin
      if (phase !== 2'b00 || active_way !== 2'd0 || lights !== 8'b10101000) begin
        $display("FAIL rest_green[%0d]: phase=%0d way=%0d lights=%b, want 0 0 10101000",
                 i, phase, active_way, lights);
        failed++;
      end
      tests++;
      tick(1);
    end
  endtask

  task automatic test_single_request;
    logic [1:0] ph_e [0:8];
    logic [1:0] w_e  [0:8];
    ph_e = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
    w_e  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    do_reset(4'b0100);
    for (int i = 0; i < 9; i++) begin
      if (phase !== ph_e[i] || active_way !== w_e[i] || lights !== exp_lights(ph_e[i], w_e[i])) begin
        $display("FAIL single_req[%0d]: phase=%0d way=%0d lights=%b, want %0d %0d %b",
                 i, phase, active_way, lights, ph_e[i], w_e[i], exp_lights(ph_e[i], w_e[i]));
        failed++;
      end
      tests++;
      tick(1);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] ways [0:3];
    logic [1:0] eph;
    ways = '{2'd0, 2'd1, 2'd3, 2'd0};
    do_reset(4'b1011);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 19; i++) begin
        if (s == 3 && i >= 3) break;
        eph = (i < 16) ? 2'd0 : ((i < 18) ? 2'd1 : 2'd2);
        if (phase !== eph || active_way !== ways[s] || lights !== exp_lights(eph, ways[s])) begin
          $display("FAIL round_robin[%0d.%0d]: phase=%0d way=%0d lights=%b, want %0d %0d",
                   s, i, phase, active_way, lights, eph, ways[s]);
          failed++;
        end
        tests++;
        tick(1);
      end
    end
  endtask

  task automatic test_preempt;
    logic [1:0] ph_e [0:5];
    logic [1:0] w_e  [0:5];
    do_reset(4'b1111);
    tick(1);
    if (phase !== 2'd0 || active_way !== 2'd0) begin
      $display("FAIL preempt_pre: phase=%0d way=%0d, want 0 0", phase, active_way);
      failed++;
    end
    tests++;
    preempt_req = 1'b1;
    preempt_way = 2'd3;
    ph_e = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    w_e  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (phase !== ph_e[i] || active_way !== w_e[i] || lights !== exp_lights(ph_e[i], w_e[i])) begin
        $display("FAIL preempt_seq[%0d]: phase=%0d way=%0d lights=%b, want %0d %0d",
                 i, phase, active_way, lights, ph_e[i], w_e[i]);
        failed++;
      end
      tests++;
    end
    // Held well past GREEN_MAX with every other way requesting
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (phase !== 2'd0 || active_way !== 2'd3 || lights !== 8'b00101010) begin
        $display("FAIL preempt_hold[%0d]: phase=%0d way=%0d lights=%b, want 0 3 00101010",
                 i, phase, active_way, lights);
        failed++;
      end
      tests++;
    end
    preempt_req = 1'b0;
    ph_e = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    w_e  = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (phase !== ph_e[i] || active_way !== w_e[i]) begin
        $display("FAIL preempt_release[%0d]: phase=%0d way=%0d, want %0d %0d",
                 i, phase, active_way, ph_e[i], w_e[i]);
        failed++;
      end
      tests++;
    end
  endtask

  task automatic test_reset_in_yellow;
    do_reset(4'b0100);
    tick(4);
    if (phase !== 2'd1 || active_way !== 2'd0) begin
      $display("FAIL ry_pre: phase=%0d way=%0d, want 1 0", phase, active_way);
      failed++;
    end
    tests++;
    #2 reset = 1'b1;
    #1;
    if (phase !== 2'd0 || active_way !== 2'd0 || lights !== 8'b10101000) begin
      $display("FAIL ry_async: phase=%0d way=%0d lights=%b, want 0 0 10101000",
               phase, active_way, lights);
      failed++;
    end
    tests++;
    tick(2);
    reset = 1'b0;
    // Timer restarted: green for exactly 4 samples again, then yellow
    for (int i = 0; i < 5; i++) begin
      if (phase !== ((i < 4) ? 2'd0 : 2'd1) || active_way !== 2'd0) begin
        $display("FAIL ry_after[%0d]: phase=%0d way=%0d, want %0d 0",
                 i, phase, active_way, (i < 4) ? 0 : 1);
        failed++;
      end
      tests++;
      tick(1);
    end
  endtask

  task automatic test_latch;
    do_reset(4'b0100);
    tick(4);
    sensor = 4'b0010;
    tick(3);
    if (phase !== 2'd0 || active_way !== 2'd2 || lights !== 8'b10001010) begin
      $display("FAIL latch: phase=%0d way=%0d lights=%b, want 0 2 10001010",
               phase, active_way, lights);
      failed++;
    end
    tests++;
  endtask

  task automatic test_preempt_in_yellow;
    do_reset(4'b0100);
    tick(4);
    preempt_req = 1'b1;
    preempt_way = 2'd1;
    tick(1);
    if (phase !== 2'd1 || active_way !== 2'd0) begin
      $display("FAIL py_yellow: phase=%0d way=%0d, want 1 0", phase, active_way);
      failed++;
    end
    tests++;
    preempt_req = 1'b0;
    tick(1);
    if (phase !== 2'd2 || lights !== 8'b10101010) begin
      $display("FAIL py_allred: phase=%0d lights=%b, want 2 10101010", phase, lights);
      failed++;
    end
    tests++;
    tick(1);
    if (phase !== 2'd0 || active_way !== 2'd1 || lights !== 8'b10100010) begin
      $display("FAIL py_green: phase=%0d way=%0d lights=%b, want 0 1 10100010",
               phase, active_way, lights);
      failed++;
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_rest_green();
    test_single_request();
    test_round_robin();
    test_preempt();
    test_reset_in_yellow();
    test_latch();
    test_preempt_in_yellow();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
